psum_tile_scheduler: RTL and testbench
======================================

// Module: psum_tile_scheduler
// PURPOSE
//  Sequences the 9-tap MAC pipeline and the 16-deep partial-sum FIFO for one
//  output tile of P pixels, iterating over C input channels.
//  - Seeds the FIFO with zeros.
//  - Issues one (channel, pixel) operation per handshake to the operand fetch unit.
//  - Drives mac_valid_1..3 and the FIFO pop/push.
//  - Flags final results.
//  Sits between the top-level loop controller and the mac / fifo instances in top_chip.
// PARAMETERS
//  TILE_PIXELS_MAX  16  psum FIFO depth = max pixels per tile
//  MAX_CHANNELS     64  max input channels per tile
// PORTS
//  clk              in   1   clock
//  arst_in          in   1   asynchronous reset, active-high
//  start            in   1   begin tile; cfg_* sampled when accepted
//  cfg_tile_pixels  in   5   P, 0..TILE_PIXELS_MAX
//  cfg_in_channels  in   7   C, 0..MAX_CHANNELS
//  busy             out  1   tile in progress
//  done             out  1   1-cycle pulse, tile finished
//  op_valid         out  1   request operands for (op_ch, op_pix)
//  op_ready         in   1   fetch unit accepts; operands in MAC regs next cycle
//  op_ch            out  6   channel index of pending op
//  op_pix           out  4   pixel index of pending op
//  mac_valid_1/2/3  out  1   MAC stage enables
//  fifo_seed        out  1   push zero into psum FIFO
//  fifo_pop         out  1   pop psum (FIFO output_ready)
//  fifo_push        out  1   push MAC result
//  out_valid        out  1   final result for out_pix on MAC output
//  out_pix          out  4   pixel index of out_valid result
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, occ = 0.
//   - Reset is asynchronous and may occur mid-tile.
//   - The psum FIFO shares the same reset, so it is empty after reset.
//  States IDLE -> SEED -> ISSUE -> DRAIN -> DONE -> IDLE.
//  IDLE
//   - start accepted only in IDLE; P and C are latched at that edge.
//   - start while busy is ignored.
//   - If P == 0 or C == 0: go directly to DONE. No seed, op or FIFO activity occurs.
//  SEED
//   - fifo_seed = 1 for exactly P cycles (pixels 0..P-1).
//  ISSUE
//   - Loop order: ch outer (0..C-1), pix inner (0..P-1).
//   - op_valid is held with op_ch/op_pix stable until op_valid & op_ready (fire).
//  Pipeline, fire in cycle t:
//   - t+1: mac_valid_1 and fifo_pop.
//   - t+2: mac_valid_2.
//   - t+3: mac_valid_3.
//   - At t+3, if ch < C-1: fifo_push = 1.
//   - At t+3, if ch == C-1: out_valid = 1 and out_pix = pix; fifo_push = 0.
//   - Result: the FIFO ends the tile empty.
//  Occupancy hazard
//   - occ is the internal count of FIFO entries.
//   - occ_next = occ + (fifo_seed | fifo_push) - fifo_pop, evaluated in the current cycle.
//   - op_valid may be asserted only when occ_next >= 1. Otherwise, insert a bubble.
//   - This guarantees the FIFO is never popped empty.
//   - The FIFO is never pushed the same-cycle value it pops.
//  ISSUE -> DRAIN after the last fire (ch = C-1, pix = P-1).
//   - DRAIN waits until the last mac_valid_3 (3 cycles with no backpressure).
//  DONE
//   - done = 1 for one cycle, then IDLE.
//  busy = 1 from the cycle after start is accepted through the done cycle inclusive.
//  fifo_seed, fifo_push and out_valid are never simultaneously high.
//   - occ never exceeds P <= TILE_PIXELS_MAX.
//  Reset mid-tile: everything returns to IDLE at once. No done pulse is produced.
// TESTING
//  T1:
//   - Stimulus: P=4, C=2, op_ready=1, start in cycle 0.
//   - Seed cycles 1-4.
//   - Fires cycles 5-12, with no bubbles.
//   - fifo_push cycles 8-11.
//   - out_valid cycles 12-15 (pix 0..3).
//   - done at cycle 16.
//  T2:
//   - Stimulus: P=1, C=3, op_ready=1.
//   - Fires at cycles 2, 5 and 8 (hazard bubbles).
//   - out_valid at cycle 11.
//   - done at cycle 12.
//   - occ never < 0.
//  T3:
//   - Stimulus: P=16, C=1.
//   - 16 seeds, then 16 pops.
//   - Zero pushes; out_valid for pix 0..15.
//   - FIFO is empty at done.
//  T4:
//   - Stimulus: P=4, C=2; op_ready low for 5 cycles at the ch1/pix2 op.
//   - op_ch/op_pix are held at 1/2.
//   - No extra mac_valid_1 pulses.
//   - Output order is unchanged.
//  T5:
//   - Stimulus: start with C=0.
//   - done on the next cycle.
//   - No seed, pop, push or op_valid.
//   - A second start during busy is ignored.
//  T6:
//   - Stimulus: arst_in pulse mid-ISSUE.
//   - All outputs are 0 immediately.
//   - No done pulse.
//   - A fresh start then reproduces the T1 timing.

Source files
------------

// File: rtl/psum_tile_scheduler.sv
// -----------------------------------------------------------------------------
// psum_tile_scheduler
//   Sequences one output tile of P pixels over C input channels. It seeds the
//   partial-sum FIFO with zeros, issues (channel, pixel) operand requests to
//   the fetch unit, drives the three MAC stage enables and the FIFO pop/push,
//   and flags the final result of each pixel on the last channel.
//
// Ports
//   clk              clock
//   arst_in          asynchronous reset, active-high
//   start            begin tile (accepted only when idle); cfg_* latched then
//   cfg_tile_pixels  P, 0..TILE_PIXELS_MAX
//   cfg_in_channels  C, 0..MAX_CHANNELS
//   busy             tile in progress (cycle after start through done cycle)
//   done             one-cycle pulse at tile end
//   op_valid         operand request for (op_ch, op_pix)
//   op_ready         fetch unit accepts the request
//   op_ch / op_pix   indices of the pending request
//   mac_valid_1..3   MAC stage enables (fire +1, +2, +3)
//   fifo_seed        push a zero into the psum FIFO
//   fifo_pop         pop a partial sum (aligned with mac_valid_1)
//   fifo_push        push a MAC result (non-final channel)
//   out_valid        final result on the MAC output for out_pix
//   out_pix          pixel index of the final result
// -----------------------------------------------------------------------------
module psum_tile_scheduler #(
  parameter int TILE_PIXELS_MAX = 16,
  parameter int MAX_CHANNELS    = 64
) (
  input  logic                                clk,
  input  logic                                arst_in,
  input  logic                                start,
  input  logic [$clog2(TILE_PIXELS_MAX):0]    cfg_tile_pixels,
  input  logic [$clog2(MAX_CHANNELS):0]       cfg_in_channels,
  output logic                                busy,
  output logic                                done,
  output logic                                op_valid,
  input  logic                                op_ready,
  output logic [$clog2(MAX_CHANNELS)-1:0]     op_ch,
  output logic [$clog2(TILE_PIXELS_MAX)-1:0]  op_pix,
  output logic                                mac_valid_1,
  output logic                                mac_valid_2,
  output logic                                mac_valid_3,
  output logic                                fifo_seed,
  output logic                                fifo_pop,
  output logic                                fifo_push,
  output logic                                out_valid,
  output logic [$clog2(TILE_PIXELS_MAX)-1:0]  out_pix
);

  localparam int PIX_W = $clog2(TILE_PIXELS_MAX);
  localparam int CH_W  = $clog2(MAX_CHANNELS);
  localparam int OCC_W = PIX_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [PIX_W:0]       r_p;
  logic [CH_W:0]        r_c;
  logic [PIX_W-1:0]     r_pix;
  logic [CH_W-1:0]      r_ch;
  logic [OCC_W-1:0]     r_occ;
  logic                 r_vld_p1, r_vld_p2, r_vld_p3;
  logic [PIX_W-1:0]     r_pix_p1, r_pix_p2, r_pix_p3;
  logic                 r_lastch_p1, r_lastch_p2, r_lastch_p3;

  logic                 w_seed, w_pop, w_push, w_out;
  logic [OCC_W-1:0]     w_occ_next;
  logic                 w_op_valid, w_fire;
  logic                 w_pix_last, w_ch_last;

  assign w_pix_last = ({1'b0, r_pix} == (r_p - (PIX_W+1)'(1)));
  assign w_ch_last  = ({1'b0, r_ch}  == (r_c - (CH_W+1)'(1)));

  assign w_seed = (r_state == S_SEED);
  assign w_pop  = r_vld_p1;
  assign w_push = r_vld_p3 & ~r_lastch_p3;
  assign w_out  = r_vld_p3 &  r_lastch_p3;

  // Entries left after this cycle's push/pop; a new op pops one cycle after
  // it fires, so requiring at least one entry here keeps the FIFO from ever
  // being popped empty.
  assign w_occ_next = r_occ + OCC_W'(w_seed | w_push) - OCC_W'(w_pop);
  assign w_op_valid = (r_state == S_ISSUE) && (w_occ_next != '0);
  assign w_fire     = w_op_valid & op_ready;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)
                 w_state_next = ((cfg_tile_pixels == '0) || (cfg_in_channels == '0))
                                ? S_DONE : S_SEED;
      S_SEED:  if (w_pix_last) w_state_next = S_ISSUE;
      S_ISSUE: if (w_fire && w_pix_last && w_ch_last) w_state_next = S_DRAIN;
      // Only the last op is in flight; once it leaves stages 1 and 2 it is
      // on stage 3 this cycle.
      S_DRAIN: if (!r_vld_p1 && !r_vld_p2) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_p         <= '0;
      r_c         <= '0;
      r_pix       <= '0;
      r_ch        <= '0;
      r_occ       <= '0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_vld_p3    <= 1'b0;
      r_pix_p1    <= '0;
      r_pix_p2    <= '0;
      r_pix_p3    <= '0;
      r_lastch_p1 <= 1'b0;
      r_lastch_p2 <= 1'b0;
      r_lastch_p3 <= 1'b0;
    end else begin
      r_occ <= w_occ_next;
      // fire -> p1 (mac_valid_1, pop)
      r_vld_p1    <= w_fire;
      r_pix_p1    <= r_pix;
      r_lastch_p1 <= w_ch_last;
      // p1 -> p2 (mac_valid_2)
      r_vld_p2    <= r_vld_p1;
      r_pix_p2    <= r_pix_p1;
      r_lastch_p2 <= r_lastch_p1;
      // p2 -> p3 (mac_valid_3, push or final result)
      r_vld_p3    <= r_vld_p2;
      r_pix_p3    <= r_pix_p2;
      r_lastch_p3 <= r_lastch_p2;

      case (r_state)
        S_IDLE: if (start) begin
          r_p   <= cfg_tile_pixels;
          r_c   <= cfg_in_channels;
          r_pix <= '0;
          r_ch  <= '0;
        end
        // r_pix doubles as the seed counter and wraps to 0 for ISSUE.
        S_SEED: r_pix <= w_pix_last ? '0 : r_pix + 1'b1;
        S_ISSUE: if (w_fire) begin
          if (w_pix_last) begin
            r_pix <= '0;
            r_ch  <= r_ch + 1'b1;
          end else begin
            r_pix <= r_pix + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign op_valid    = w_op_valid;
  assign op_ch       = (r_state == S_ISSUE) ? r_ch  : '0;
  assign op_pix      = (r_state == S_ISSUE) ? r_pix : '0;
  assign mac_valid_1 = r_vld_p1;
  assign mac_valid_2 = r_vld_p2;
  assign mac_valid_3 = r_vld_p3;
  assign fifo_seed   = w_seed;
  assign fifo_pop    = w_pop;
  assign fifo_push   = w_push;
  assign out_valid   = w_out;
  assign out_pix     = w_out ? r_pix_p3 : '0;

endmodule

// File: tb/tb_psum_tile_scheduler.sv
module tb_psum_tile_scheduler;

  localparam int NMAX = 2048;

  logic       clk = 1'b0;
  logic       arst_in, start, op_ready;
  logic [4:0] cfg_tile_pixels;
  logic [6:0] cfg_in_channels;
  logic       busy, done, op_valid;
  logic [5:0] op_ch;
  logic [3:0] op_pix;
  logic       mac_valid_1, mac_valid_2, mac_valid_3;
  logic       fifo_seed, fifo_pop, fifo_push, out_valid;
  logic [3:0] out_pix;

  int tests = 0;
  int fails = 0;

  // Future-event table of the reference model, indexed by cycle.
  bit e1 [NMAX];
  bit e2 [NMAX];
  bit e3 [NMAX];
  bit elast [NMAX];
  int epix [NMAX];

  psum_tile_scheduler dut (
    .clk(clk), .arst_in(arst_in), .start(start),
    .cfg_tile_pixels(cfg_tile_pixels), .cfg_in_channels(cfg_in_channels),
    .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
    .op_ch(op_ch), .op_pix(op_pix),
    .mac_valid_1(mac_valid_1), .mac_valid_2(mac_valid_2), .mac_valid_3(mac_valid_3),
    .fifo_seed(fifo_seed), .fifo_pop(fifo_pop), .fifo_push(fifo_push),
    .out_valid(out_valid), .out_pix(out_pix)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_opv"}, op_valid, 0);
    chk({tag, "_opch"}, op_ch, 0);
    chk({tag, "_oppix"}, op_pix, 0);
    chk({tag, "_mv1"}, mac_valid_1, 0);
    chk({tag, "_mv2"}, mac_valid_2, 0);
    chk({tag, "_mv3"}, mac_valid_3, 0);
    chk({tag, "_seed"}, fifo_seed, 0);
    chk({tag, "_pop"}, fifo_pop, 0);
    chk({tag, "_push"}, fifo_push, 0);
    chk({tag, "_outv"}, out_valid, 0);
    chk({tag, "_outpix"}, out_pix, 0);
  endtask

  // mode 0: op_ready always high; 1: random op_ready;
  // 2: op_ready low for 5 cycles while the ch1/pix2 op is offered.
  // abort_at: pulse reset in that cycle. restart_at: extra start in that cycle.
  task automatic run_tile(input string tag, input int P, input int C, input int mode,
                          input int abort_at, input int restart_at);
    int total, seeded, n, occ, done_cyc, stall, ch, pix, occn;
    int n_seed, n_pop, n_push, n_out, n_mv1;
    bit zero, seed, issuing, pop, push, outv, opv, rdy, finished;
    total = P * C; seeded = 0; n = 0; occ = 0; stall = 0; finished = 0;
    n_seed = 0; n_pop = 0; n_push = 0; n_out = 0; n_mv1 = 0;
    zero = (P == 0) || (C == 0);
    for (int i = 0; i < NMAX; i++) begin
      e1[i] = 0; e2[i] = 0; e3[i] = 0; elast[i] = 0; epix[i] = 0;
    end
    @(posedge clk); #1;
    start = 1'b1; cfg_tile_pixels = 5'(P); cfg_in_channels = 7'(C); op_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = zero ? 1 : -1;
    for (int k = 1; k < NMAX - 4; k++) begin
      seed    = !zero && (seeded < P);
      issuing = !zero && !seed && (n < total);
      ch      = (P > 0) ? n / P : 0;
      pix     = (P > 0) ? n % P : 0;
      pop     = e1[k];
      push    = e3[k] && !elast[k];
      outv    = e3[k] && elast[k];
      occn    = occ + ((seed || push) ? 1 : 0) - (pop ? 1 : 0);
      opv     = issuing && (occn >= 1);
      if (k == restart_at) begin
        start = 1'b1; cfg_tile_pixels = 5'd3; cfg_in_channels = 7'd5;
      end else begin
        start = 1'b0;
      end
      if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && opv && ch == 1 && pix == 2 && stall < 5) begin
        rdy = 1'b0; stall++;
      end else rdy = 1'b1;
      op_ready = rdy;
      if (k == abort_at) begin
        arst_in = 1'b1;
        #1;
        chk_all_zero({tag, "_arst"});
        @(posedge clk); #1;
        arst_in = 1'b0; start = 1'b0; op_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk({tag, "_postrst_done"}, done, 0);
          chk({tag, "_postrst_busy"}, busy, 0);
        end
        return;
      end
      @(negedge clk);
      chk({tag, "_busy"}, busy, (done_cyc < 0 || k <= done_cyc) ? 1 : 0);
      chk({tag, "_done"}, done, (k == done_cyc) ? 1 : 0);
      chk({tag, "_seed"}, fifo_seed, seed ? 1 : 0);
      chk({tag, "_pop"}, fifo_pop, pop ? 1 : 0);
      chk({tag, "_mv1"}, mac_valid_1, pop ? 1 : 0);
      chk({tag, "_mv2"}, mac_valid_2, e2[k] ? 1 : 0);
      chk({tag, "_mv3"}, mac_valid_3, e3[k] ? 1 : 0);
      chk({tag, "_push"}, fifo_push, push ? 1 : 0);
      chk({tag, "_outv"}, out_valid, outv ? 1 : 0);
      if (outv) chk({tag, "_outpix"}, out_pix, epix[k]);
      chk({tag, "_opv"}, op_valid, opv ? 1 : 0);
      if (opv) begin
        chk({tag, "_opch"}, op_ch, ch);
        chk({tag, "_oppix"}, op_pix, pix);
      end
      n_seed += int'(fifo_seed); n_pop += int'(fifo_pop);
      n_push += int'(fifo_push); n_out += int'(out_valid);
      n_mv1  += int'(mac_valid_1);
      if (seed) seeded++;
      occ = occn;
      if (opv && rdy) begin
        e1[k+1] = 1; e2[k+2] = 1; e3[k+3] = 1;
        epix[k+3] = pix; elast[k+3] = (ch == C - 1);
        n++;
        if (n == total) done_cyc = k + 4;
      end
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_nseed"}, n_seed, zero ? 0 : P);
    chk({tag, "_npop"}, n_pop, total);
    chk({tag, "_nmv1"}, n_mv1, total);
    chk({tag, "_npush"}, n_push, zero ? 0 : P * (C - 1));
    chk({tag, "_nout"}, n_out, zero ? 0 : P);
    chk({tag, "_fifo_empty"}, n_seed + n_push - n_pop, 0);
  endtask

  initial begin
    arst_in = 1'b1; start = 1'b0; op_ready = 1'b0;
    cfg_tile_pixels = '0; cfg_in_channels = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    arst_in = 1'b0;

    run_tile("t1", 4, 2, 0, -1, -1);
    run_tile("t2", 1, 3, 0, -1, -1);
    run_tile("t3", 16, 1, 0, -1, -1);
    run_tile("t4", 4, 2, 2, -1, -1);
    run_tile("t5c0", 4, 0, 0, -1, 1);
    run_tile("t5p0", 0, 5, 0, -1, -1);
    run_tile("t1busy", 4, 2, 0, -1, 6);
    run_tile("t6abort", 4, 2, 0, 8, -1);
    run_tile("t6again", 4, 2, 0, -1, -1);
    run_tile("c64", 3, 64, 1, -1, -1);
    for (int r = 0; r < 12; r++) begin
      run_tile("rand", int'($urandom_range(1, 16)), int'($urandom_range(1, 6)), 1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
